mem_bus_arbiter: RTL

- Two-master to one-slave arbiter for the 32-bit valid/ready memory bus driven by the riscv_min core.
- Master 0 is the RISC-V core. Master 1 is a secondary requester (286 bridge or DMA).
- Round-robin grant; every transaction is held atomic from start to completion; optional lock for read-modify-write; optional slave-timeout watchdog.

---
 rtl/mem_bus_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 27 ++
 rtl/bus_watchdog.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 32-bit valid/ready memory bus: widths, arbiter
// state encodings, the request bundle and the default timeout read data.
package mem_bus_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LANE_W  = 4;
    localparam int TIMER_W = 16;

    // Read data handed back to a master whose slave cycle timed out.
    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY   = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    // Everything a master must hold stable while its request is pending.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dout;
        logic              wr;
        logic [LANE_W-1:0] lane;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One valid/ready memory bus port. "master" is the requester side, "slave"
// the responder side; the arbiter is a slave to each core port and a master
// towards the memory.
interface mem_bus_arbiter_if;
    import mem_bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;   // write data, master -> slave
    logic              wr;
    logic [LANE_W-1:0] lane;
    logic              valid;
    logic              lock;   // keep ownership after this transfer
    logic [DATA_W-1:0] din;    // read data, slave -> master
    logic              ready;  // completion pulse
    logic              err;    // completion was a timeout

    modport master (
        output addr, dout, wr, lane, valid, lock,
        input  din, ready, err
    );

    modport slave (
        input  addr, dout, wr, lane, valid, lock,
        output din, ready, err
    );

endinterface

// File: rtl/bus_watchdog.sv
// Saturating cycle timer for an outstanding slave cycle. Raises expire in
// the cycle where the count reaches TIMEOUT-1; TIMEOUT=0 disables it.
module bus_watchdog
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,     // restart from zero (new slave cycle issued)
    input  logic en,      // count while the slave cycle is outstanding
    output logic expire
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    // Next count: clear wins over counting; stop at all-ones instead of wrapping.
    always_comb begin
        if (clr) begin
            timer_d = '0;
        end else if (en && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire = (TIMEOUT != 0) && (timer_q == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the memory bus. Master 0 is
// the RISC-V core, master 1 a secondary requester. Each transfer is atomic;
// a master holding lock keeps ownership across transfers; an optional
// watchdog completes a stuck slave cycle with an error.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned        TIMEOUT  = 0,
    parameter logic [DATA_W-1:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    m0,
    mem_bus_arbiter_if.slave    m1,
    mem_bus_arbiter_if.master   s,
    output logic                grant
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    bus_req_t   s_req_q, s_req_d;
    logic       s_valid_q, s_valid_d;

    bus_req_t [1:0] m_req;
    logic     [1:0] m_valid;
    logic     [1:0] m_lock;

    logic issue;
    logic issue_sel;
    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    logic              cpl;
    logic              cpl_err;
    logic [DATA_W-1:0] cpl_din;

    assign m_req[0] = '{addr: m0.addr, dout: m0.dout, wr: m0.wr, lane: m0.lane};
    assign m_req[1] = '{addr: m1.addr, dout: m1.dout, wr: m1.wr, lane: m1.lane};
    assign m_valid  = {m1.valid, m0.valid};
    assign m_lock   = {m1.lock,  m0.lock};

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Arbitration and transfer sequencing: decide the next owner and state.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        s_req_d   = s_req_q;
        s_valid_d = s_valid_q;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        issue     = 1'b0;
        issue_sel = grant_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (|m_valid) begin
                    issue = 1'b1;
                    // On a tie the master that did not own the bus last wins.
                    issue_sel = (&m_valid) ? ~grant_q : m_valid[1];
                end
            end
            ARB_BUSY: begin
                wd_en = 1'b1;
                if (s.ready || wd_expire) begin
                    s_valid_d = 1'b0;
                    state_d   = m_lock[grant_q] ? ARB_LOCKED : ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (m_valid[grant_q]) begin
                    issue = 1'b1;
                end else if (!m_lock[grant_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (issue) begin
            s_req_d   = m_req[issue_sel];
            s_valid_d = 1'b1;
            grant_d   = issue_sel;
            wd_clr    = 1'b1;
            state_d   = ARB_BUSY;
        end
    end

    // FSM and registered slave-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= 1'b1;   // makes m0 the winner of the first tie
            s_req_q   <= '0;
            s_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            s_req_q   <= s_req_d;
            s_valid_q <= s_valid_d;
        end
    end

    // A slave response in the expiry cycle takes precedence over the timeout.
    assign cpl     = (state_q == ARB_BUSY) && (s.ready || wd_expire);
    assign cpl_err = (state_q == ARB_BUSY) && !s.ready && wd_expire;
    assign cpl_din = s.ready ? s.din : ERR_DATA;

    // Completion is steered to the owner only; read data is zero otherwise.
    assign m0.ready = cpl && !grant_q;
    assign m0.err   = cpl_err && !grant_q;
    assign m0.din   = (cpl && !grant_q) ? cpl_din : '0;
    assign m1.ready = cpl && grant_q;
    assign m1.err   = cpl_err && grant_q;
    assign m1.din   = (cpl && grant_q) ? cpl_din : '0;

    assign s.addr  = s_req_q.addr;
    assign s.dout  = s_req_q.dout;
    assign s.wr    = s_req_q.wr;
    assign s.lane  = s_req_q.lane;
    assign s.valid = s_valid_q;
    assign s.lock  = 1'b0;

    assign grant = grant_q;

endmodule
